// File: rtl/video_mode_detect.sv
// Video timing detector: sync polarity, total/active sizes, lock tracking and pixel position.
// Define VIDEO_MODE_DETECT_CHECKSUM_EN to build the per-frame R+G+B checksum.
module video_mode_detect #(
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned LOCK_FRAMES = 3
) (
    input  logic             CLK_VIDEO,
    input  logic             RESET,
    input  logic             CE_PIXEL,
    input  logic [7:0]       VGA_R,
    input  logic [7:0]       VGA_G,
    input  logic [7:0]       VGA_B,
    input  logic             VGA_HS,
    input  logic             VGA_VS,
    input  logic             VGA_DE,
    output logic [CNT_W-1:0] hactive,
    output logic [CNT_W-1:0] vactive,
    output logic [CNT_W-1:0] htotal,
    output logic [CNT_W-1:0] vtotal,
    output logic             hs_pol,
    output logic             vs_pol,
    output logic             locked,
    output logic             new_frame,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic [15:0]      checksum
);

    typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_t;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [3:0]       LockM1 = 4'(LOCK_FRAMES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CntOne;
    endfunction

    state_t           state;
    logic             primed, hs_prev, vs_prev, de_prev, line_de;
    logic             hs_lead, vs_lead, de_rise, de_fall, same_set;
    logic [CNT_W-1:0] h_cnt, de_cnt, v_cnt, va_cnt, htot_last, hact_last;
    logic [CNT_W-1:0] htot_new, hact_new, vact_new;
    logic [3:0]       match_cnt, match_inc;

    // Previous sample is normalised with the current polarity so a polarity flip is not an edge.
    always_comb begin
        hs_lead   = primed & (VGA_HS ^ ~hs_pol) & ~(hs_prev ^ ~hs_pol);
        vs_lead   = primed & (VGA_VS ^ ~vs_pol) & ~(vs_prev ^ ~vs_pol);
        de_rise   = primed & VGA_DE & ~de_prev;
        de_fall   = primed & ~VGA_DE & de_prev;
        htot_new  = hs_lead ? h_cnt : htot_last;
        hact_new  = (hs_lead && line_de) ? de_cnt : hact_last;
        vact_new  = (hs_lead && line_de) ? sat_inc(va_cnt) : va_cnt;
        same_set  = {htot_new, v_cnt, hact_new, vact_new} == {htotal, vtotal, hactive, vactive};
        match_inc = (match_cnt == 4'hf) ? match_cnt : match_cnt + 4'd1;
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (RESET) begin
            primed    <= 1'b0;
            hs_prev   <= 1'b0;
            vs_prev   <= 1'b0;
            de_prev   <= 1'b0;
            hs_pol    <= 1'b1;
            vs_pol    <= 1'b1;
            h_cnt     <= '0;
            de_cnt    <= '0;
            v_cnt     <= '0;
            va_cnt    <= '0;
            htot_last <= '0;
            hact_last <= '0;
            line_de   <= 1'b0;
            x         <= '0;
            y         <= '0;
        end else if (CE_PIXEL) begin
            primed  <= 1'b1;
            hs_prev <= VGA_HS;
            vs_prev <= VGA_VS;
            de_prev <= VGA_DE;
            if (de_rise) begin
                hs_pol <= ~VGA_HS;
                vs_pol <= ~VGA_VS;
            end
            if (hs_lead) begin
                h_cnt     <= CntOne;
                htot_last <= h_cnt;
                de_cnt    <= VGA_DE ? CntOne : '0;
                line_de   <= VGA_DE;
                if (line_de) begin
                    hact_last <= de_cnt;
                    va_cnt    <= sat_inc(va_cnt);
                end
            end else begin
                h_cnt   <= sat_inc(h_cnt);
                line_de <= line_de | VGA_DE;
                if (VGA_DE) de_cnt <= sat_inc(de_cnt);
            end
            // A coincident line start is line 0 of the new frame.
            if (vs_lead) begin
                v_cnt  <= hs_lead ? CntOne : '0;
                va_cnt <= '0;
            end else if (hs_lead) begin
                v_cnt <= sat_inc(v_cnt);
            end
            if (de_rise) x <= '0;
            else if (VGA_DE) x <= sat_inc(x);
            if (vs_lead) y <= '0;
            else if (de_fall) y <= sat_inc(y);
        end
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (RESET) begin
            state     <= StSearch;
            locked    <= 1'b0;
            new_frame <= 1'b0;
            match_cnt <= '0;
            htotal    <= '0;
            vtotal    <= '0;
            hactive   <= '0;
            vactive   <= '0;
        end else begin
            new_frame <= 1'b0;
            if (CE_PIXEL && vs_lead) begin
                if (state == StSearch) begin
                    state <= StMeasure;
                end else begin
                    htotal    <= htot_new;
                    vtotal    <= v_cnt;
                    hactive   <= hact_new;
                    vactive   <= vact_new;
                    new_frame <= 1'b1;
                    if (same_set) begin
                        match_cnt <= match_inc;
                        if (match_inc >= LockM1) begin
                            state  <= StLocked;
                            locked <= 1'b1;
                        end
                    end else begin
                        match_cnt <= '0;
                        state     <= StMeasure;
                        locked    <= 1'b0;
                    end
                end
            end else if (CE_PIXEL && v_cnt == CntMax && state != StSearch) begin
                // Line counter pinned without a frame start: signal lost.
                state     <= StSearch;
                locked    <= 1'b0;
                match_cnt <= '0;
            end
        end
    end

`ifdef VIDEO_MODE_DETECT_CHECKSUM_EN
    logic [15:0] sum_acc, rgb_sum;
    assign rgb_sum = 16'(VGA_R) + 16'(VGA_G) + 16'(VGA_B);

    always_ff @(posedge CLK_VIDEO) begin
        if (RESET) begin
            sum_acc  <= '0;
            checksum <= '0;
        end else if (CE_PIXEL) begin
            if (vs_lead) sum_acc <= VGA_DE ? rgb_sum : 16'd0;
            else if (VGA_DE) sum_acc <= sum_acc + rgb_sum;
            if (vs_lead && state != StSearch) checksum <= sum_acc;
        end
    end
`else
    logic unused_rgb;
    assign unused_rgb = ^{VGA_R, VGA_G, VGA_B};
    assign checksum   = 16'd0;
`endif

endmodule
